moore_table_fsm: RTL and testbench

Parametrised, table-driven Moore state machine. State count, input width and output width are set by parameters. The next-state and per-state output tables are loaded at run time through a configuration write port. Used wherever the design needs a small sequencer whose transition graph changes between builds or modes. Adds enable gating, a dwell counter, and explicit flagging of inputs that have no defined transition.

---
 rtl/moore_table_fsm.sv | 99 +++++++++
 tb/tb_moore_table_fsm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/moore_table_fsm.sv
// moore_table_fsm: Moore sequencer whose transition graph and per-state
// outputs live in run-time writable tables. Adds enable gating, a
// saturating dwell counter and a flag for inputs with no defined transition.
module moore_table_fsm #(
  parameter int ST_W     = 2,
  parameter int IN_W     = 2,
  parameter int OUT_W    = 2,
  parameter int CNT_W    = 8,
  parameter int RESET_ST = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [IN_W-1:0]  InData,
  input  logic             TrWe,
  input  logic [ST_W-1:0]  TrState,
  input  logic [IN_W-1:0]  TrIn,
  input  logic [ST_W-1:0]  TrNext,
  input  logic             TrValid,
  input  logic             OutWe,
  input  logic [ST_W-1:0]  OutState,
  input  logic [OUT_W-1:0] OutVal,
  output logic [ST_W-1:0]  State,
  output logic [OUT_W-1:0] OutData,
  output logic             Changed,
  output logic             Miss,
  output logic [CNT_W-1:0] Dwell
);

  localparam int NUM_ST = 2 ** ST_W;
  localparam int IDX_W  = ST_W + IN_W;
  localparam int NUM_TR = 2 ** IDX_W;

  // Transition table entries {valid, next} and the per-state output table
  logic [NUM_TR-1:0] tr_valid;
  logic [ST_W-1:0]   tr_next [NUM_TR];
  logic [OUT_W-1:0]  out_tab [NUM_ST];

  logic [IDX_W-1:0]  lk_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              e_valid;
  logic [ST_W-1:0]   e_next;
  logic              take;
  logic              moved;
  logic [ST_W-1:0]   enter;
  logic [OUT_W-1:0]  out_enter;

  // Dwell counter increment that sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign lk_idx  = {State, InData};
  assign wr_idx  = {TrState, TrIn};
  // Lookup reads the table before this edge's write lands
  assign e_valid = tr_valid[lk_idx];
  assign e_next  = tr_next[lk_idx];
  assign take    = Enable && e_valid;
  assign moved   = take && (e_next != State);
  assign enter   = take ? e_next : State;
  // A write to the output entry of the state being entered wins over the old value
  assign out_enter = (OutWe && (OutState == enter)) ? OutVal : out_tab[enter];

  // Configuration writes: accepted every cycle, independent of Enable
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tr_valid <= '0;
      for (int i = 0; i < NUM_TR; i++) tr_next[i] <= '0;
      for (int i = 0; i < NUM_ST; i++) out_tab[i] <= '0;
    end else begin
      if (TrWe) begin
        tr_valid[wr_idx] <= TrValid;
        tr_next[wr_idx]  <= TrNext;
      end
      if (OutWe) out_tab[OutState] <= OutVal;
    end
  end

  // State register with registered Moore output, event pulses and dwell count
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      State   <= ST_W'(RESET_ST);
      OutData <= '0;
      Changed <= 1'b0;
      Miss    <= 1'b0;
      Dwell   <= '0;
    end else if (Enable) begin
      State   <= enter;
      OutData <= out_enter;
      Changed <= moved;
      Miss    <= !e_valid;
      Dwell   <= moved ? '0 : sat_inc(Dwell);
    end else begin
      Changed <= 1'b0;
      Miss    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moore_table_fsm.sv
// tb_moore_table_fsm: directed vector bench for moore_table_fsm with the
// dwell counter narrowed to 4 bits so saturation is reachable quickly.
module tb_moore_table_fsm;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Enable;
  logic [1:0] InData;
  logic       TrWe;
  logic [1:0] TrState;
  logic [1:0] TrIn;
  logic [1:0] TrNext;
  logic       TrValid;
  logic       OutWe;
  logic [1:0] OutState;
  logic [1:0] OutVal;
  logic [1:0] State;
  logic [1:0] OutData;
  logic       Changed;
  logic       Miss;
  logic [3:0] Dwell;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic [1:0] in;
    int         st;
    int         od;
    int         ch;
    int         ms;
    int         dw;
  } vec_t;

  vec_t vecs [15];

  moore_table_fsm #(
    .ST_W(2), .IN_W(2), .OUT_W(2), .CNT_W(4), .RESET_ST(0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .InData(InData),
    .TrWe(TrWe), .TrState(TrState), .TrIn(TrIn), .TrNext(TrNext),
    .TrValid(TrValid), .OutWe(OutWe), .OutState(OutState), .OutVal(OutVal),
    .State(State), .OutData(OutData), .Changed(Changed), .Miss(Miss),
    .Dwell(Dwell)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int st, input int od,
                         input int ch, input int ms, input int dw);
    chk({nm, ".State"},   int'(State),   st);
    chk({nm, ".OutData"}, int'(OutData), od);
    chk({nm, ".Changed"}, int'(Changed), ch);
    chk({nm, ".Miss"},    int'(Miss),    ms);
    chk({nm, ".Dwell"},   int'(Dwell),   dw);
  endtask

  task automatic tr_write(input logic [1:0] s, input logic [1:0] i,
                          input logic [1:0] n, input logic v);
    @(negedge Clk);
    Enable = 1'b0; TrWe = 1'b1; TrState = s; TrIn = i; TrNext = n; TrValid = v;
    @(posedge Clk); #1;
    TrWe = 1'b0;
  endtask

  task automatic out_write(input logic [1:0] s, input logic [1:0] v);
    @(negedge Clk);
    Enable = 1'b0; OutWe = 1'b1; OutState = s; OutVal = v;
    @(posedge Clk); #1;
    OutWe = 1'b0;
  endtask

  task automatic step(input logic [1:0] in);
    @(negedge Clk);
    Enable = 1'b1; InData = in;
    @(posedge Clk); #1;
  endtask

  initial begin
    // {en, in, State, OutData, Changed, Miss, Dwell}
    vecs[0]  = '{1'b1, 2'b01, 0, 1, 0, 1, 2};  // undefined input in A
    vecs[1]  = '{1'b1, 2'b11, 0, 1, 0, 0, 3};  // A self-loop keeps counting
    vecs[2]  = '{1'b1, 2'b00, 1, 0, 1, 0, 0};
    vecs[3]  = '{1'b1, 2'b01, 2, 3, 1, 0, 0};
    vecs[4]  = '{1'b1, 2'b11, 3, 2, 1, 0, 0};
    vecs[5]  = '{1'b1, 2'b01, 2, 3, 1, 0, 0};
    vecs[6]  = '{1'b1, 2'b10, 2, 3, 0, 0, 1};  // C self-loop
    vecs[7]  = '{1'b1, 2'b11, 3, 2, 1, 0, 0};
    vecs[8]  = '{1'b1, 2'b10, 1, 0, 1, 0, 0};
    vecs[9]  = '{1'b0, 2'b01, 1, 0, 0, 0, 0};  // enable low, frozen in B
    vecs[10] = '{1'b0, 2'b01, 1, 0, 0, 0, 0};
    vecs[11] = '{1'b0, 2'b01, 1, 0, 0, 0, 0};
    vecs[12] = '{1'b1, 2'b01, 2, 3, 1, 0, 0};  // enable back, B->C
    vecs[13] = '{1'b1, 2'b11, 3, 2, 1, 0, 0};
    vecs[14] = '{1'b1, 2'b10, 1, 0, 1, 0, 0};

    Reset = 1'b1; Enable = 1'b0; InData = '0;
    TrWe = 1'b0; TrState = '0; TrIn = '0; TrNext = '0; TrValid = 1'b0;
    OutWe = 1'b0; OutState = '0; OutVal = '0;

    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Empty table: first enabled edge flags a miss
    step(2'b00);
    chk_all("empty", 0, 0, 0, 1, 1);

    // Program the graph A=0,B=1,C=2,D=3 and outputs
    tr_write(2'd0, 2'b11, 2'd0, 1'b1);
    tr_write(2'd0, 2'b00, 2'd1, 1'b1);
    tr_write(2'd1, 2'b00, 2'd1, 1'b1);
    tr_write(2'd1, 2'b01, 2'd2, 1'b1);
    tr_write(2'd2, 2'b10, 2'd2, 1'b1);
    tr_write(2'd2, 2'b11, 2'd3, 1'b1);
    tr_write(2'd3, 2'b01, 2'd2, 1'b1);
    tr_write(2'd3, 2'b10, 2'd1, 1'b1);
    out_write(2'd0, 2'b01);
    out_write(2'd1, 2'b00);
    out_write(2'd2, 2'b11);
    out_write(2'd3, 2'b10);
    chk("cfg_hold.State", int'(State), 0);
    chk("cfg_hold.Dwell", int'(Dwell), 1);

    for (int k = 0; k < 15; k++) begin
      @(negedge Clk);
      Enable = vecs[k].en; InData = vecs[k].in;
      @(posedge Clk); #1;
      chk_all($sformatf("vec%0d", k), vecs[k].st, vecs[k].od,
              vecs[k].ch, vecs[k].ms, vecs[k].dw);
    end

    // Output write-through on the B->C edge
    @(negedge Clk);
    Enable = 1'b1; InData = 2'b01;
    OutWe = 1'b1; OutState = 2'd2; OutVal = 2'b01;
    @(posedge Clk); #1;
    OutWe = 1'b0;
    chk_all("wthru", 2, 1, 1, 0, 0);

    // Transition write to the entry being looked up: old entry (C->D) wins
    @(negedge Clk);
    Enable = 1'b1; InData = 2'b11;
    TrWe = 1'b1; TrState = 2'd2; TrIn = 2'b11; TrNext = 2'd0; TrValid = 1'b1;
    @(posedge Clk); #1;
    TrWe = 1'b0;
    chk_all("trcoll", 3, 2, 1, 0, 0);

    // New entry is in place afterwards: D->B, B->C, then C->A
    step(2'b10);
    chk_all("d_to_b", 1, 0, 1, 0, 0);
    step(2'b01);
    chk_all("b_to_c", 2, 1, 1, 0, 0);
    step(2'b11);
    chk_all("newtr", 0, 1, 1, 0, 0);

    // Dwell saturation on the A self-loop
    for (int k = 0; k < 20; k++) begin
      step(2'b11);
      chk($sformatf("dwell%0d", k), int'(Dwell), (k + 1 > 15) ? 15 : k + 1);
    end
    chk_all("dwell_end", 0, 1, 0, 0, 15);

    // Restore C->D and walk to D
    tr_write(2'd2, 2'b11, 2'd3, 1'b1);
    step(2'b00);
    step(2'b01);
    step(2'b11);
    chk_all("in_d", 3, 2, 1, 0, 0);

    // Asynchronous reset between edges
    @(negedge Clk);
    Enable = 1'b1; InData = 2'b01;
    #2 Reset = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    #1 Reset = 1'b0;
    @(posedge Clk); #1;
    chk_all("post_rst", 0, 0, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
